ysyx_22040895_wbu: RTL and testbench

//  Writeback unit: the initiator side of the GPR file write port. Accepts results from EXU and LSU

---
 rtl/ysyx_22040895_pkg.sv | 12 +
 rtl/ysyx_22040895_wb_fifo.sv | 58 +++++
 rtl/ysyx_22040895_wbu.sv | 99 +++++++++
 tb/tb_ysyx_22040895_wbu.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040895_pkg.sv
// Shared writeback types: GPR data/address widths and the queued entry.
package ysyx_22040895_pkg;

  localparam int XLEN = 64;
  localparam int RAW  = 5;

  typedef struct packed {
    logic [RAW-1:0]  rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/ysyx_22040895_wb_fifo.sv
// In-order circular buffer for pending GPR writes.
// All slots are exposed so the top can search them for forwarding.
module ysyx_22040895_wb_fifo
  import ysyx_22040895_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  wb_entry_t             din_i,
  input  logic                  pop_i,
  output wb_entry_t             head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CW-1:0]         count_o,
  output logic [AW-1:0]         rptr_o,
  output wb_entry_t [DEPTH-1:0] mem_o
);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] cnt_q;

  // Power-of-two depth: pointer increments wrap on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop_i) begin
        rptr_q <= rptr_q + AW'(1);
      end
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rptr_o  = rptr_q;
  assign mem_o   = mem_q;

endmodule

// File: rtl/ysyx_22040895_wbu.sv
// Writeback unit: LSU/EXU arbitration into an in-order write queue,
// one regfile write per cycle, and two youngest-match forwarding ports.
module ysyx_22040895_wbu
  import ysyx_22040895_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exu_valid_i,
  output logic            exu_ready_o,
  input  logic [RAW-1:0]  exu_rd_i,
  input  logic [XLEN-1:0] exu_data_i,
  input  logic            lsu_valid_i,
  output logic            lsu_ready_o,
  input  logic [RAW-1:0]  lsu_rd_i,
  input  logic [XLEN-1:0] lsu_data_i,
  input  logic            wb_stall_i,
  output logic            we_o,
  output logic [RAW-1:0]  waddr_o,
  output logic [XLEN-1:0] wdata_o,
  input  logic [RAW-1:0]  q1_addr_i,
  output logic            q1_hit_o,
  output logic [XLEN-1:0] q1_data_o,
  input  logic [RAW-1:0]  q2_addr_i,
  output logic            q2_hit_o,
  output logic [XLEN-1:0] q2_data_o,
  output logic [CW-1:0]   count_o
);

  wb_entry_t             din;
  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] mem;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         cnt;
  logic [AW-1:0]         rptr;
  logic                  lsu_fire;
  logic                  exu_fire;
  logic                  push;
  logic                  pop;

  assign lsu_ready_o = !full;
  assign exu_ready_o = !full && !lsu_valid_i;
  assign lsu_fire    = lsu_valid_i && lsu_ready_o;
  assign exu_fire    = exu_valid_i && exu_ready_o;

  assign din.rd   = lsu_fire ? lsu_rd_i : exu_rd_i;
  assign din.data = lsu_fire ? lsu_data_i : exu_data_i;
  // x0 writes complete the handshake but are never queued.
  assign push = (lsu_fire || exu_fire) && (din.rd != '0);

  assign we_o    = !empty && !wb_stall_i;
  assign pop     = we_o;
  assign waddr_o = we_o ? head.rd : '0;
  assign wdata_o = we_o ? head.data : '0;
  assign count_o = cnt;

  ysyx_22040895_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (din),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (cnt),
    .rptr_o  (rptr),
    .mem_o   (mem)
  );

  // Walk oldest to youngest so the last match wins.
  function automatic logic [XLEN:0] fwd(
    input logic [RAW-1:0]        a,
    input wb_entry_t [DEPTH-1:0] m,
    input logic [AW-1:0]         rp,
    input logic [CW-1:0]         n
  );
    logic [XLEN:0] r;
    logic [AW-1:0] idx;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rp + AW'(i);
      if (CW'(i) < n && m[idx].rd == a && a != '0) begin
        r = {1'b1, m[idx].data};
      end
    end
    return r;
  endfunction

  always_comb begin
    {q1_hit_o, q1_data_o} = fwd(q1_addr_i, mem, rptr, cnt);
    {q2_hit_o, q2_data_o} = fwd(q2_addr_i, mem, rptr, cnt);
  end

endmodule

// File: tb/tb_ysyx_22040895_wbu.sv
// Directed bench for the writeback unit.
module tb_ysyx_22040895_wbu;

  logic        clk;
  logic        rst;
  logic        exu_valid_i;
  logic        exu_ready_o;
  logic [4:0]  exu_rd_i;
  logic [63:0] exu_data_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_rd_i;
  logic [63:0] lsu_data_i;
  logic        wb_stall_i;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [63:0] wdata_o;
  logic [4:0]  q1_addr_i;
  logic        q1_hit_o;
  logic [63:0] q1_data_o;
  logic [4:0]  q2_addr_i;
  logic        q2_hit_o;
  logic [63:0] q2_data_o;
  logic [2:0]  count_o;

  int checks;
  int failures;

  ysyx_22040895_wbu #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .exu_valid_i (exu_valid_i),
    .exu_ready_o (exu_ready_o),
    .exu_rd_i    (exu_rd_i),
    .exu_data_i  (exu_data_i),
    .lsu_valid_i (lsu_valid_i),
    .lsu_ready_o (lsu_ready_o),
    .lsu_rd_i    (lsu_rd_i),
    .lsu_data_i  (lsu_data_i),
    .wb_stall_i  (wb_stall_i),
    .we_o        (we_o),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o),
    .q1_addr_i   (q1_addr_i),
    .q1_hit_o    (q1_hit_o),
    .q1_data_o   (q1_data_o),
    .q2_addr_i   (q2_addr_i),
    .q2_hit_o    (q2_hit_o),
    .q2_data_o   (q2_data_o),
    .count_o     (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    exu_valid_i = 1'b0;
    lsu_valid_i = 1'b0;
    exu_rd_i    = '0;
    exu_data_i  = '0;
    lsu_rd_i    = '0;
    lsu_data_i  = '0;
  endtask

  task automatic push_exu(input logic [4:0] rd, input logic [63:0] d);
    exu_valid_i = 1'b1;
    exu_rd_i    = rd;
    exu_data_i  = d;
    step();
    exu_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    wb_stall_i = 1'b0;
    q1_addr_i  = '0;
    q2_addr_i  = '0;
    rst = 1'b0;
    #12;
    checks++;
    if (count_o !== 3'd0 || we_o !== 1'b0 || waddr_o !== 5'd0
        || wdata_o !== 64'd0 || q1_hit_o !== 1'b0 || q1_data_o !== 64'd0) begin
      failures++;
      $display("FAIL reset_state cnt=%0d we=%b wa=%0d wd=%h h=%b qd=%h",
               count_o, we_o, waddr_o, wdata_o, q1_hit_o, q1_data_o);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    wb_stall_i = 1'b1;
    push_exu(5'd1, 64'h1);
    push_exu(5'd2, 64'h2);
    push_exu(5'd3, 64'h3);
    checks++;
    if (count_o !== 3'd3) begin
      failures++;
      $display("FAIL mid_fill count got=%0d want=3", count_o);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (count_o !== 3'd0 || we_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset cnt=%0d we=%b want 0 0", count_o, we_o);
    end
    wb_stall_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (we_o !== 1'b0 || count_o !== 3'd0) begin
        failures++;
        $display("FAIL post_reset_write we=%b cnt=%0d want 0 0", we_o, count_o);
      end
    end
  endtask

  task automatic test_priority();
    lsu_valid_i = 1'b1;
    lsu_rd_i    = 5'd5;
    lsu_data_i  = 64'hAA;
    exu_valid_i = 1'b1;
    exu_rd_i    = 5'd6;
    exu_data_i  = 64'hBB;
    #1;
    checks++;
    if (lsu_ready_o !== 1'b1 || exu_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL prio_ready lsu=%b exu=%b want 1 0", lsu_ready_o, exu_ready_o);
    end
    step();
    lsu_valid_i = 1'b0;
    #1;
    checks++;
    if (we_o !== 1'b1 || waddr_o !== 5'd5 || wdata_o !== 64'hAA
        || exu_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL prio_lsu_write we=%b wa=%0d wd=%h er=%b want 1 5 aa 1",
               we_o, waddr_o, wdata_o, exu_ready_o);
    end
    step();
    exu_valid_i = 1'b0;
    #1;
    checks++;
    if (we_o !== 1'b1 || waddr_o !== 5'd6 || wdata_o !== 64'hBB) begin
      failures++;
      $display("FAIL prio_exu_write we=%b wa=%0d wd=%h want 1 6 bb",
               we_o, waddr_o, wdata_o);
    end
    step();
    checks++;
    if (we_o !== 1'b0 || count_o !== 3'd0) begin
      failures++;
      $display("FAIL prio_drained we=%b cnt=%0d want 0 0", we_o, count_o);
    end
  endtask

  task automatic test_x0();
    exu_valid_i = 1'b1;
    exu_rd_i    = 5'd0;
    exu_data_i  = 64'h1234;
    q1_addr_i   = 5'd0;
    #1;
    checks++;
    if (exu_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL x0_ready got=%b want 1", exu_ready_o);
    end
    step();
    idle();
    #1;
    checks++;
    if (count_o !== 3'd0 || we_o !== 1'b0 || q1_hit_o !== 1'b0) begin
      failures++;
      $display("FAIL x0_dropped cnt=%0d we=%b hit=%b want 0 0 0",
               count_o, we_o, q1_hit_o);
    end
  endtask

  task automatic test_full_wrap();
    logic [4:0] base;
    for (int r = 0; r < 2; r++) begin
      base = (r == 0) ? 5'd1 : 5'd8;
      wb_stall_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
        push_exu(base + 5'(i), 64'hF00 + 64'(base) + 64'(i));
      end
      lsu_valid_i = 1'b1;
      lsu_rd_i    = 5'd20;
      #1;
      checks++;
      if (count_o !== 3'd4 || exu_ready_o !== 1'b0 || lsu_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL full_state r=%0d cnt=%0d er=%b lr=%b want 4 0 0",
                 r, count_o, exu_ready_o, lsu_ready_o);
      end
      wb_stall_i = 1'b0;
      #1;
      checks++;
      if (lsu_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL full_pop_ready r=%0d got=%b want 0", r, lsu_ready_o);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (we_o !== 1'b1 || waddr_o !== base + 5'(i)
            || wdata_o !== 64'hF00 + 64'(base) + 64'(i)) begin
          failures++;
          $display("FAIL drain_order r=%0d i=%0d we=%b wa=%0d wd=%h",
                   r, i, we_o, waddr_o, wdata_o);
        end
        if (i == 0) lsu_valid_i = 1'b0;
        step();
      end
      checks++;
      if (count_o !== 3'd0 || we_o !== 1'b0) begin
        failures++;
        $display("FAIL drain_empty r=%0d cnt=%0d we=%b", r, count_o, we_o);
      end
    end
  endtask

  task automatic test_forward();
    wb_stall_i = 1'b1;
    q1_addr_i  = 5'd7;
    q2_addr_i  = 5'd8;
    push_exu(5'd7, 64'h11);
    push_exu(5'd7, 64'h22);
    #1;
    checks++;
    if (q1_hit_o !== 1'b1 || q1_data_o !== 64'h22
        || q2_hit_o !== 1'b0 || q2_data_o !== 64'h0) begin
      failures++;
      $display("FAIL fwd_youngest h1=%b d1=%h h2=%b d2=%h want 1 22 0 0",
               q1_hit_o, q1_data_o, q2_hit_o, q2_data_o);
    end
    wb_stall_i = 1'b0;
    #1;
    checks++;
    if (q1_hit_o !== 1'b1 || we_o !== 1'b1 || wdata_o !== 64'h11) begin
      failures++;
      $display("FAIL fwd_popping hit=%b we=%b wd=%h want 1 1 11",
               q1_hit_o, we_o, wdata_o);
    end
    step();
    checks++;
    if (q1_hit_o !== 1'b1 || q1_data_o !== 64'h22) begin
      failures++;
      $display("FAIL fwd_after_pop1 hit=%b d=%h want 1 22", q1_hit_o, q1_data_o);
    end
    step();
    checks++;
    if (q1_hit_o !== 1'b0 || q1_data_o !== 64'h0) begin
      failures++;
      $display("FAIL fwd_after_pop2 hit=%b d=%h want 0 0", q1_hit_o, q1_data_o);
    end
    q1_addr_i = '0;
    q2_addr_i = '0;
  endtask

  task automatic test_back_to_back();
    logic [4:0]  rd;
    logic [63:0] d;
    wb_stall_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rd = 5'((i % 31) + 1);
      d  = 64'(i * 3 + 100);
      exu_valid_i = 1'b1;
      exu_rd_i    = rd;
      exu_data_i  = d;
      step();
      checks++;
      if (we_o !== 1'b1 || waddr_o !== rd || wdata_o !== d || count_o > 3'd1) begin
        failures++;
        $display("FAIL steady i=%0d we=%b wa=%0d wd=%h cnt=%0d want wa=%0d wd=%h",
                 i, we_o, waddr_o, wdata_o, count_o, rd, d);
      end
    end
    idle();
    step();
    checks++;
    if (count_o !== 3'd0 || we_o !== 1'b0) begin
      failures++;
      $display("FAIL steady_end cnt=%0d we=%b want 0 0", count_o, we_o);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_reset_mid();
    test_priority();
    test_x0();
    test_full_wrap();
    test_forward();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
